// File: rtl/e203_dtcm_icb_bist.sv
// e203_dtcm_icb_bist: DTCM built-in self test engine.
// Acts as an ICB initiator on the DTCM external-agent port. It writes
// pattern = seed ^ address over a word range, then reads the range back and
// compares each word against the same pattern.
// Optional feature macro: E203_DTCM_BIST_STOP_ON_ERR_EN
//   defined   -> stop issuing commands at the first error, drain, finish
//   undefined -> every enabled phase completes all word_cnt commands
// The companion checker module e203_dtcm_icb_bist_chk holds the
// simulation assertions on the outstanding-command bookkeeping.

module e203_dtcm_icb_bist_chk #(
  parameter int OUTS_NUM = 1
) (
  input logic       clk,
  input logic       rst_n,
  input logic       rsp_valid,
  input logic       rsp_ready,
  input logic       cmd_valid,
  input logic [2:0] outs
);
  localparam logic [2:0] OUTS_MAX = 3'(OUTS_NUM);

  // A response must never arrive while nothing is outstanding.
  a_no_orphan_rsp: assert property (@(posedge clk) disable iff (!rst_n)
    (rsp_valid && rsp_ready) |-> (outs != 3'd0));

  // The outstanding count stays within the configured limit.
  a_outs_limit: assert property (@(posedge clk) disable iff (!rst_n)
    outs <= OUTS_MAX);

  // A command is only presented while there is room for one more.
  a_valid_room: assert property (@(posedge clk) disable iff (!rst_n)
    cmd_valid |-> (outs < OUTS_MAX));
endmodule

module e203_dtcm_icb_bist #(
  parameter int AW       = 16,
  parameter int CW       = 14,
  parameter int OUTS_NUM = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [1:0]    mode,
  input  logic [AW-1:0] base_addr,
  input  logic [CW-1:0] word_cnt,
  input  logic [31:0]   seed,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] err_addr,
  output logic          icb_cmd_valid,
  input  logic          icb_cmd_ready,
  output logic [AW-1:0] icb_cmd_addr,
  output logic          icb_cmd_read,
  output logic [31:0]   icb_cmd_wdata,
  output logic [3:0]    icb_cmd_wmask,
  input  logic          icb_rsp_valid,
  output logic          icb_rsp_ready,
  input  logic          icb_rsp_err,
  input  logic [31:0]   icb_rsp_rdata
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WR     = 3'd1,
    ST_WDRAIN = 3'd2,
    ST_RD     = 3'd3,
    ST_RDRAIN = 3'd4,
    ST_FIN    = 3'd5
  } state_t;

  localparam logic [2:0]    OUTS_MAX  = 3'(OUTS_NUM);
  localparam logic [AW-1:0] ADDR_STEP = AW'(32'd4);
  localparam logic [CW-1:0] CNT_ONE   = CW'(32'd1);

  // Expected word content for a given byte address.
  function automatic logic [31:0] pattern_f(input logic [31:0] s, input logic [AW-1:0] a);
    return s ^ 32'(a);
  endfunction

  state_t        state_r, state_nxt_s;
  logic          chk_en_r, chk_en_nxt_s;
  logic [AW-1:0] base_r, base_nxt_s;
  logic [CW-1:0] cnt_r, cnt_nxt_s;
  logic [31:0]   seed_r, seed_nxt_s;
  logic [CW-1:0] left_r, left_nxt_s;
  logic [AW-1:0] addr_r, addr_nxt_s;
  logic [AW-1:0] rsp_addr_r, rsp_addr_nxt_s;
  logic [2:0]    outs_r, outs_nxt_s;
  logic          cmd_valid_r, valid_nxt_s;
  logic          cmd_read_r, read_nxt_s;
  logic [31:0]   wdata_r, wdata_nxt_s;
  logic          busy_r, busy_nxt_s;
  logic          done_r, done_nxt_s;
  logic          err_r, err_nxt_s;
  logic [AW-1:0] err_addr_r, err_addr_nxt_s;

  logic          cmd_hs_s;
  logic          rsp_hs_s;
  logic          rd_phase_s;
  logic          fail_s;
  logic          start_acc_s;
  logic          stop_s;
  logic [AW-1:0] base_aligned_s;
  logic          unused_s;

  assign base_aligned_s = {base_addr[AW-1:2], 2'b00};
  assign unused_s       = ^base_addr[1:0];
  assign cmd_hs_s       = cmd_valid_r & icb_cmd_ready;
  // Responses with nothing outstanding are ignored.
  assign rsp_hs_s       = icb_rsp_valid & busy_r & (outs_r != 3'd0);
  assign rd_phase_s     = (state_r == ST_RD) || (state_r == ST_RDRAIN);
  assign fail_s         = rsp_hs_s & (icb_rsp_err |
                          (rd_phase_s & (icb_rsp_rdata != pattern_f(seed_r, rsp_addr_r))));
  assign start_acc_s    = start & (state_r == ST_IDLE);

`ifdef E203_DTCM_BIST_STOP_ON_ERR_EN
  // An error seen now or earlier in this run halts new command issue.
  assign stop_s = (err_r & ~start_acc_s) | fail_s;
`else
  assign stop_s = 1'b0;
`endif

  // Outstanding counter update: command handshake adds, response handshake removes.
  always_comb begin
    outs_nxt_s = outs_r;
    case ({cmd_hs_s, rsp_hs_s})
      2'b10:   outs_nxt_s = outs_r + 3'd1;
      2'b01:   outs_nxt_s = outs_r - 3'd1;
      default: outs_nxt_s = outs_r;
    endcase
  end

  // Phase sequencing plus the address/count registers that each phase reloads.
  always_comb begin
    state_nxt_s    = state_r;
    chk_en_nxt_s   = chk_en_r;
    base_nxt_s     = base_r;
    cnt_nxt_s      = cnt_r;
    seed_nxt_s     = seed_r;
    left_nxt_s     = cmd_hs_s ? (left_r - CNT_ONE) : left_r;
    addr_nxt_s     = cmd_hs_s ? (addr_r + ADDR_STEP) : addr_r;
    rsp_addr_nxt_s = rsp_hs_s ? (rsp_addr_r + ADDR_STEP) : rsp_addr_r;
    case (state_r)
      ST_IDLE: begin
        if (start_acc_s) begin
          chk_en_nxt_s   = mode[1];
          base_nxt_s     = base_aligned_s;
          cnt_nxt_s      = word_cnt;
          seed_nxt_s     = seed;
          left_nxt_s     = word_cnt;
          addr_nxt_s     = base_aligned_s;
          rsp_addr_nxt_s = base_aligned_s;
          if (mode[0]) begin
            state_nxt_s = ST_WR;
          end else if (mode[1]) begin
            state_nxt_s = ST_RD;
          end else begin
            state_nxt_s = ST_FIN;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WR: begin
        if ((left_nxt_s == {CW{1'b0}}) || (stop_s && (!cmd_valid_r || cmd_hs_s))) begin
          state_nxt_s = ST_WDRAIN;
        end else begin
          state_nxt_s = ST_WR;
        end
      end
      ST_WDRAIN: begin
        if (outs_r == 3'd0) begin
          if (chk_en_r && !stop_s) begin
            state_nxt_s    = ST_RD;
            left_nxt_s     = cnt_r;
            addr_nxt_s     = base_r;
            rsp_addr_nxt_s = base_r;
          end else begin
            state_nxt_s = ST_FIN;
          end
        end else begin
          state_nxt_s = ST_WDRAIN;
        end
      end
      ST_RD: begin
        if ((left_nxt_s == {CW{1'b0}}) || (stop_s && (!cmd_valid_r || cmd_hs_s))) begin
          state_nxt_s = ST_RDRAIN;
        end else begin
          state_nxt_s = ST_RD;
        end
      end
      ST_RDRAIN: begin
        if (outs_r == 3'd0) begin
          state_nxt_s = ST_FIN;
        end else begin
          state_nxt_s = ST_RDRAIN;
        end
      end
      ST_FIN:  state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Command channel, status and error capture for the next cycle.
  always_comb begin
    valid_nxt_s    = 1'b0;
    read_nxt_s     = (state_nxt_s == ST_RD);
    wdata_nxt_s    = 32'h0000_0000;
    busy_nxt_s     = (state_nxt_s != ST_IDLE) && (state_nxt_s != ST_FIN);
    done_nxt_s     = (state_nxt_s == ST_FIN);
    err_nxt_s      = err_r;
    err_addr_nxt_s = err_addr_r;
    if (cmd_valid_r && !icb_cmd_ready) begin
      valid_nxt_s = 1'b1;
    end else if (((state_nxt_s == ST_WR) || (state_nxt_s == ST_RD)) &&
                 (left_nxt_s != {CW{1'b0}}) && (outs_nxt_s < OUTS_MAX) && !stop_s) begin
      valid_nxt_s = 1'b1;
    end else begin
      valid_nxt_s = 1'b0;
    end
    if (state_nxt_s == ST_WR) begin
      wdata_nxt_s = pattern_f(seed_nxt_s, addr_nxt_s);
    end else begin
      wdata_nxt_s = 32'h0000_0000;
    end
    if (start_acc_s) begin
      err_nxt_s      = 1'b0;
      err_addr_nxt_s = {AW{1'b0}};
    end else if (fail_s && !err_r) begin
      err_nxt_s      = 1'b1;
      err_addr_nxt_s = rsp_addr_r;
    end else begin
      err_nxt_s      = err_r;
      err_addr_nxt_s = err_addr_r;
    end
  end

  // State and output registers; reset drops straight back to idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      chk_en_r    <= 1'b0;
      base_r      <= {AW{1'b0}};
      cnt_r       <= {CW{1'b0}};
      seed_r      <= 32'h0000_0000;
      left_r      <= {CW{1'b0}};
      addr_r      <= {AW{1'b0}};
      rsp_addr_r  <= {AW{1'b0}};
      outs_r      <= 3'd0;
      cmd_valid_r <= 1'b0;
      cmd_read_r  <= 1'b0;
      wdata_r     <= 32'h0000_0000;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      err_addr_r  <= {AW{1'b0}};
    end else begin
      state_r     <= state_nxt_s;
      chk_en_r    <= chk_en_nxt_s;
      base_r      <= base_nxt_s;
      cnt_r       <= cnt_nxt_s;
      seed_r      <= seed_nxt_s;
      left_r      <= left_nxt_s;
      addr_r      <= addr_nxt_s;
      rsp_addr_r  <= rsp_addr_nxt_s;
      outs_r      <= outs_nxt_s;
      cmd_valid_r <= valid_nxt_s;
      cmd_read_r  <= read_nxt_s;
      wdata_r     <= wdata_nxt_s;
      busy_r      <= busy_nxt_s;
      done_r      <= done_nxt_s;
      err_r       <= err_nxt_s;
      err_addr_r  <= err_addr_nxt_s;
    end
  end

  assign busy          = busy_r;
  assign done          = done_r;
  assign err           = err_r;
  assign err_addr      = err_addr_r;
  assign icb_cmd_valid = cmd_valid_r;
  assign icb_cmd_addr  = addr_r;
  assign icb_cmd_read  = cmd_read_r;
  assign icb_cmd_wdata = wdata_r;
  assign icb_cmd_wmask = 4'hF;
  assign icb_rsp_ready = busy_r;

  e203_dtcm_icb_bist_chk #(.OUTS_NUM(OUTS_NUM)) u_chk (
    .clk       (clk),
    .rst_n     (rst_n),
    .rsp_valid (icb_rsp_valid),
    .rsp_ready (icb_rsp_ready),
    .cmd_valid (cmd_valid_r),
    .outs      (outs_r)
  );

endmodule

// File: tb/tb_e203_dtcm_icb_bist.sv
// Scoreboard bench for e203_dtcm_icb_bist: expected ICB commands and
// completion status are queued when a run is launched; a monitor pops and
// compares them as the DUT handshakes commands and pulses done.
`timescale 1ns/1ps
module tb_e203_dtcm_icb_bist;
  localparam int AW = 16;
  localparam int CW = 14;
  localparam int OUTS_NUM = 2;
`ifdef E203_DTCM_BIST_STOP_ON_ERR_EN
  localparam bit STOP_EN = 1'b1;
`else
  localparam bit STOP_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic [AW-1:0] base_addr = '0;
  logic [CW-1:0] word_cnt = '0;
  logic [31:0]   seed = '0;
  logic          busy, done, err;
  logic [AW-1:0] err_addr;
  logic          icb_cmd_valid;
  logic          icb_cmd_ready = 1'b0;
  logic [AW-1:0] icb_cmd_addr;
  logic          icb_cmd_read;
  logic [31:0]   icb_cmd_wdata;
  logic [3:0]    icb_cmd_wmask;
  logic          icb_rsp_valid = 1'b0;
  logic          icb_rsp_ready;
  logic          icb_rsp_err = 1'b0;
  logic [31:0]   icb_rsp_rdata = '0;

  always #5 clk = ~clk;

  e203_dtcm_icb_bist #(.AW(AW), .CW(CW), .OUTS_NUM(OUTS_NUM)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .base_addr(base_addr),
    .word_cnt(word_cnt), .seed(seed), .busy(busy), .done(done), .err(err),
    .err_addr(err_addr), .icb_cmd_valid(icb_cmd_valid), .icb_cmd_ready(icb_cmd_ready),
    .icb_cmd_addr(icb_cmd_addr), .icb_cmd_read(icb_cmd_read), .icb_cmd_wdata(icb_cmd_wdata),
    .icb_cmd_wmask(icb_cmd_wmask), .icb_rsp_valid(icb_rsp_valid), .icb_rsp_ready(icb_rsp_ready),
    .icb_rsp_err(icb_rsp_err), .icb_rsp_rdata(icb_rsp_rdata)
  );

  typedef struct { logic [AW-1:0] addr; logic read; logic [31:0] wdata; } cmd_t;
  typedef struct { logic err; logic [AW-1:0] err_addr; } fin_t;
  typedef struct { int due; logic err; logic [31:0] data; } rsp_t;

  cmd_t        exp_cmd_q[$];
  fin_t        exp_fin_q[$];
  rsp_t        rq[$];
  logic [31:0] mem [int];

  int n_checks = 0;
  int n_errors = 0;
  int lat = 0;
  int cyc = 0;
  int cmd_idx = 0;
  int stall_idx = -1;
  int stall_left = 0;
  int outs_tb = 0;
  int max_outs = 0;
  logic          corrupt_en = 1'b0;
  logic [AW-1:0] corrupt_addr = '0;
  logic          werr_en = 1'b0;
  logic [AW-1:0] werr_addr = '0;
  logic          valid_seen = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push_cmd(input logic [AW-1:0] a, input logic rd, input logic [31:0] wd);
    cmd_t c;
    c.addr = a; c.read = rd; c.wdata = wd;
    exp_cmd_q.push_back(c);
  endtask

  // Expected command list for one phase built from the pattern definition.
  task automatic push_phase(input logic [AW-1:0] b, input int cnt, input logic [31:0] s, input logic rd);
    logic [AW-1:0] a;
    for (int i = 0; i < cnt; i++) begin
      a = b + AW'(4 * i);
      push_cmd(a, rd, rd ? 32'h0 : (s ^ 32'(a)));
    end
  endtask

  task automatic push_fin(input logic e, input logic [AW-1:0] ea);
    fin_t f;
    f.err = e; f.err_addr = ea;
    exp_fin_q.push_back(f);
  endtask

  // Launch a run, optionally poke a stray start while busy, wait for done.
  task automatic run(input logic [1:0] m, input logic [AW-1:0] b, input logic [CW-1:0] c,
                     input logic [31:0] s, input int inj, input bit lenient, output int cycles);
    cmd_idx = 0;
    @(negedge clk);
    mode = m; base_addr = b; word_cnt = c; seed = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cycles = 1;
    while (!done && cycles < 400) begin
      @(negedge clk);
      cycles++;
      if (cycles == inj) begin
        mode = 2'b01; base_addr = 16'h0800; word_cnt = 14'd3; seed = 32'h0; start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    if (!done) begin
      n_checks++; n_errors++;
      $display("FAIL run_timeout: done not seen after %0d cycles, required within 400", cycles);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      exp_fin_q.delete();
      rst_n = 1'b1;
    end else begin
      @(negedge clk);
      chk("done_pulse_width", 32'(done), 32'h0);
    end
    repeat (2) @(negedge clk);
    if (lenient) exp_cmd_q.delete();
    chk("cmds_not_issued", exp_cmd_q.size(), 32'h0);
    exp_cmd_q.delete();
  endtask

  // Responder: memory model with configurable latency, stall and corruption.
  always @(negedge clk) begin
    rsp_t r;
    if (!rst_n) begin
      icb_cmd_ready = 1'b0; icb_rsp_valid = 1'b0; icb_rsp_err = 1'b0; icb_rsp_rdata = 32'h0;
      rq.delete(); outs_tb = 0;
    end else begin
      cyc++;
      icb_rsp_valid = 1'b0; icb_rsp_err = 1'b0; icb_rsp_rdata = 32'h0;
      if (rq.size() != 0 && rq[0].due <= cyc && busy) begin
        r = rq.pop_front();
        icb_rsp_valid = 1'b1; icb_rsp_err = r.err; icb_rsp_rdata = r.data;
        outs_tb--;
      end
      icb_cmd_ready = 1'b1;
      if (icb_cmd_valid) begin
        if (cmd_idx == stall_idx && stall_left > 0) begin
          icb_cmd_ready = 1'b0;
          stall_left--;
          chk("stall_addr", 32'(icb_cmd_addr), 32'h0000_0104);
          chk("stall_wdata", icb_cmd_wdata, 32'hA5A5_A4A1);
          chk("stall_read", 32'(icb_cmd_read), 32'h0);
        end else begin
          r.due = cyc + 1 + lat; r.err = 1'b0; r.data = 32'h0;
          if (icb_cmd_read) begin
            r.data = mem.exists(int'(icb_cmd_addr)) ? mem[int'(icb_cmd_addr)] : 32'h0;
            if (corrupt_en && icb_cmd_addr == corrupt_addr) r.data = r.data ^ 32'h0000_0100;
          end else begin
            mem[int'(icb_cmd_addr)] = icb_cmd_wdata;
            r.err = werr_en && (icb_cmd_addr == werr_addr);
          end
          rq.push_back(r);
          outs_tb++; cmd_idx++;
          if (outs_tb > max_outs) max_outs = outs_tb;
          chk("outs_within_limit", 32'(outs_tb <= OUTS_NUM), 32'h1);
        end
      end
    end
  end

  // Monitor: compares handshaked commands and done pulses against the queues.
  always @(negedge clk) begin
    cmd_t e;
    fin_t f;
    #1;
    if (rst_n) begin
      if (icb_cmd_valid) valid_seen = 1'b1;
      if (icb_cmd_valid && icb_cmd_ready) begin
        if (exp_cmd_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL unexpected_cmd: got addr %h read %0d, expected no command", icb_cmd_addr, icb_cmd_read);
        end else begin
          e = exp_cmd_q.pop_front();
          chk("cmd_addr", 32'(icb_cmd_addr), 32'(e.addr));
          chk("cmd_read", 32'(icb_cmd_read), 32'(e.read));
          chk("cmd_wmask", 32'(icb_cmd_wmask), 32'hF);
          if (!e.read) chk("cmd_wdata", icb_cmd_wdata, e.wdata);
        end
      end
      if (done) begin
        if (exp_fin_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL unexpected_done: got done=1, expected 0");
        end else begin
          f = exp_fin_q.pop_front();
          chk("done_err", 32'(err), 32'(f.err));
          chk("done_err_addr", 32'(err_addr), 32'(f.err_addr));
          chk("done_busy", 32'(busy), 32'h0);
        end
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_done"}, 32'(done), 32'h0);
    chk({tag, "_err"}, 32'(err), 32'h0);
    chk({tag, "_err_addr"}, 32'(err_addr), 32'h0);
    chk({tag, "_cmd_valid"}, 32'(icb_cmd_valid), 32'h0);
    chk({tag, "_cmd_read"}, 32'(icb_cmd_read), 32'h0);
    chk({tag, "_rsp_ready"}, 32'(icb_rsp_ready), 32'h0);
    chk({tag, "_cmd_addr"}, 32'(icb_cmd_addr), 32'h0);
    chk({tag, "_cmd_wdata"}, icb_cmd_wdata, 32'h0);
  endtask

  task automatic push_t1();
    push_cmd(16'h0100, 1'b0, 32'hA5A5_A4A5);
    push_cmd(16'h0104, 1'b0, 32'hA5A5_A4A1);
    push_cmd(16'h0108, 1'b0, 32'hA5A5_A4AD);
    push_cmd(16'h010C, 1'b0, 32'hA5A5_A4A9);
    push_cmd(16'h0100, 1'b1, 32'h0);
    push_cmd(16'h0104, 1'b1, 32'h0);
    push_cmd(16'h0108, 1'b1, 32'h0);
    push_cmd(16'h010C, 1'b1, 32'h0);
    push_fin(1'b0, 16'h0000);
  endtask

  initial begin
    int cycles;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Basic write/check pass.
    push_t1();
    run(2'b11, 16'h0100, 14'd4, 32'hA5A5_A5A5, -1, 1'b0, cycles);

    // Read data corrupted at 0x108.
    corrupt_en = 1'b1; corrupt_addr = 16'h0108;
    push_phase(16'h0100, 4, 32'hA5A5_A5A5, 1'b0);
    push_phase(16'h0100, 4, 32'hA5A5_A5A5, 1'b1);
    push_fin(1'b1, 16'h0108);
    run(2'b11, 16'h0100, 14'd4, 32'hA5A5_A5A5, -1, STOP_EN, cycles);
    corrupt_en = 1'b0;

    // Second write held off by cmd_ready for five cycles.
    stall_idx = 1; stall_left = 5;
    push_t1();
    run(2'b11, 16'h0100, 14'd4, 32'hA5A5_A5A5, -1, 1'b0, cycles);
    chk("stall_consumed", 32'(stall_left), 32'h0);
    stall_idx = -1;

    // Three-cycle response latency exercises the outstanding limit.
    lat = 3; max_outs = 0;
    push_phase(16'h0200, 6, 32'h1234_5678, 1'b0);
    push_phase(16'h0200, 6, 32'h1234_5678, 1'b1);
    push_fin(1'b0, 16'h0000);
    run(2'b11, 16'h0200, 14'd6, 32'h1234_5678, -1, 1'b0, cycles);
    chk("max_outstanding", 32'(max_outs), 32'(OUTS_NUM));
    lat = 0;

    // Address wrap at the top of the 16-bit space.
    push_cmd(16'hFFF8, 1'b0, 32'hDEAD_4117);
    push_cmd(16'hFFFC, 1'b0, 32'hDEAD_4113);
    push_cmd(16'h0000, 1'b0, 32'hDEAD_BEEF);
    push_cmd(16'h0004, 1'b0, 32'hDEAD_BEEB);
    push_cmd(16'hFFF8, 1'b1, 32'h0);
    push_cmd(16'hFFFC, 1'b1, 32'h0);
    push_cmd(16'h0000, 1'b1, 32'h0);
    push_cmd(16'h0004, 1'b1, 32'h0);
    push_fin(1'b0, 16'h0000);
    run(2'b11, 16'hFFF8, 14'd4, 32'hDEAD_BEEF, -1, 1'b0, cycles);

    // No phases enabled.
    valid_seen = 1'b0;
    push_fin(1'b0, 16'h0000);
    run(2'b00, 16'h0100, 14'd4, 32'h0, -1, 1'b0, cycles);
    chk("mode0_done_within_3", 32'(cycles <= 3), 32'h1);
    chk("mode0_no_valid", 32'(valid_seen), 32'h0);

    // Zero word count with the write phase enabled.
    valid_seen = 1'b0;
    push_fin(1'b0, 16'h0000);
    run(2'b01, 16'h0100, 14'd0, 32'h0, -1, 1'b0, cycles);
    chk("cnt0_done_within_3", 32'(cycles <= 3), 32'h1);
    chk("cnt0_no_valid", 32'(valid_seen), 32'h0);

    // Error response during the write phase.
    werr_en = 1'b1; werr_addr = 16'h0304;
    push_phase(16'h0300, 3, 32'h0BAD_F00D, 1'b0);
    push_phase(16'h0300, 3, 32'h0BAD_F00D, 1'b1);
    push_fin(1'b1, 16'h0304);
    run(2'b11, 16'h0300, 14'd3, 32'h0BAD_F00D, -1, STOP_EN, cycles);
    werr_en = 1'b0;

    // A second start while busy must be ignored.
    push_phase(16'h0400, 3, 32'h0F0F_0F0F, 1'b0);
    push_phase(16'h0400, 3, 32'h0F0F_0F0F, 1'b1);
    push_fin(1'b0, 16'h0000);
    run(2'b11, 16'h0400, 14'd3, 32'h0F0F_0F0F, 3, 1'b0, cycles);

    // Asynchronous reset in the middle of the write phase.
    lat = 3; cmd_idx = 0;
    push_phase(16'h0500, 8, 32'h5A5A_0000, 1'b0);
    @(negedge clk);
    mode = 2'b01; base_addr = 16'h0500; word_cnt = 14'd8; seed = 32'h5A5A_0000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("midwr_busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midwr_reset");
    repeat (2) @(negedge clk);
    exp_cmd_q.delete(); exp_fin_q.delete(); mem.delete();
    lat = 0;
    rst_n = 1'b1;

    // Normal operation after the reset.
    push_t1();
    run(2'b11, 16'h0100, 14'd4, 32'hA5A5_A5A5, -1, 1'b0, cycles);

    chk("fin_queue_empty", exp_fin_q.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
